link_tx_arbiter: RTL and testbench
==================================

// Module: link_tx_arbiter
// PURPOSE
//  Shares one physical inter-partition link among GATE_NUMBER gate TX channels.
//  Each channel delivers flits under a valid/ready handshake, and the block grants the link
//  in round-robin order in bounded bursts. The output carries the source index and a
//  segment-last flag so the far partition can demultiplex. It sits between the per-gate
//  TX serializers and the link PHY wrapper.
// PARAMETERS
//  GATE_NUMBER  4   number of requesting gate channels (>=2)
//  DATA_WIDTH   32  flit width in bits
//  MAX_BURST    4   max flits per grant (>=1); forces release for fairness
// PORTS
//  i_clk        in   1                 clock
//  i_rst        in   1                 reset, asynchronous, active-high
//  i_req        in   GATE_NUMBER       per-channel flit valid
//  i_data       in   GATE_NUMBER*DW    per-channel flit; channel k at [k*DW +: DW]
//  i_last       in   GATE_NUMBER       per-channel end-of-message flag, qualified by i_req
//  o_pop        out  GATE_NUMBER       one-hot; flit of channel k consumed this cycle
//  o_link_valid out  1                 link flit valid
//  o_link_data  out  DATA_WIDTH        link flit
//  o_link_src   out  $clog2(GATE_NUMBER) owning channel index
//  o_link_last  out  1                 last flit of this grant segment
//  i_link_ready in   1                 link accepts flit
//  o_busy       out  1                 a grant is held (state BURST)
// BEHAVIOUR
//  - Transfer: o_link_valid && i_link_ready. o_pop[owner] = transfer; all other o_pop bits are 0.
//  - States:
//    - IDLE: no grant; o_link_valid=0.
//      - If |i_req, the owner is the first set bit at or after ptr (cyclic). Go to BURST next cycle with cnt=0.
//    - BURST: o_link_valid=i_req[owner], o_link_data=i_data[owner], o_link_src=owner.
//      - o_link_last = i_last[owner] | (cnt==MAX_BURST-1).
//      - On transfer with o_link_last: go to IDLE and set ptr=owner+1 (mod GATE_NUMBER).
//      - On transfer without o_link_last: cnt++.
//      - When i_req[owner]==0, go to IDLE with ptr=owner+1. cnt is discarded, and the next
//        grant of that channel starts a new segment.
//  - Arbitration latency: 1 cycle. A request seen in IDLE at cycle t can transfer at cycle t+1.
//    There is exactly one IDLE cycle between consecutive grants.
//  - Link output is combinational from i_data/i_req of the owner (no storage).
//    owner, ptr, cnt and state are registered.
//  - Requests from non-owners are ignored during BURST. No preemption.
//  - i_link_ready low holds the flit. cnt, owner and output are stable until transfer or i_req[owner] drops.
//  - Widths: cnt is $clog2(MAX_BURST+1) bits. ptr/owner wrap GATE_NUMBER-1 -> 0 when
//    GATE_NUMBER is not a power of 2.
//  - Reset values: state=IDLE, ptr=0, owner=0, cnt=0, o_pop=0, o_link_valid=0,
//    o_link_last=0, o_link_src=0, o_busy=0, o_link_data=0.
//  - Reset mid-burst aborts the segment immediately with no pop. The receiver treats the
//    partial segment as discarded.
// TESTING (GATE_NUMBER=4, MAX_BURST=4, DATA_WIDTH=32)
//  1. Reset, then i_req=4'b0100 with a 2-flit message (last on flit 2), ready=1:
//     - src=2 transfers at cycles 1 and 2; o_link_last on flit 2.
//     - IDLE follows, then ptr=3.
//  2. All four i_req held high with endless messages:
//     - Grants run 0,1,2,3,0, 4 flits each, o_link_last on every 4th flit.
//     - Exactly 1 idle cycle between grants.
//  3. After a grant to channel 3 completes, i_req=4'b1001: the next owner is 0 (wrap), not 3.
//  4. i_link_ready=0 for 5 cycles mid-burst at flit 2:
//     - o_link_data and o_link_src stay stable, o_pop=0, cnt is unchanged.
//     - Resuming delivers flits 2..4 and then releases.
//  5. Owner drops i_req after 1 flit (ready=1):
//     - Return to IDLE with no pop that cycle; the next requester is granted.
//     - The dropped channel is re-granted later with cnt=0.
//  6. Assert i_rst while owner=1, cnt=2:
//     - All outputs go to 0 asynchronously, the next grant starts from ptr=0, and no extra pop occurs.

Source files
------------

// File: rtl/link_tx_arbiter_if.sv
// link_tx_arbiter_if: per-gate flit requests in, shared link flit out.
// master = gate/PHY side, slave = arbiter.
interface link_tx_arbiter_if #(
   parameter int GATE_NUMBER = 4,
   parameter int DATA_WIDTH  = 32
);
   localparam int SW = $clog2(GATE_NUMBER);
   logic [GATE_NUMBER-1:0]            i_req;
   logic [GATE_NUMBER*DATA_WIDTH-1:0] i_data;
   logic [GATE_NUMBER-1:0]            i_last;
   logic [GATE_NUMBER-1:0]            o_pop;
   logic                              o_link_valid;
   logic [DATA_WIDTH-1:0]             o_link_data;
   logic [SW-1:0]                     o_link_src;
   logic                              o_link_last;
   logic                              i_link_ready;
   logic                              o_busy;
   modport master (
      output i_req, i_data, i_last, i_link_ready,
      input  o_pop, o_link_valid, o_link_data, o_link_src, o_link_last, o_busy
   );
   modport slave (
      input  i_req, i_data, i_last, i_link_ready,
      output o_pop, o_link_valid, o_link_data, o_link_src, o_link_last, o_busy
   );
endinterface

// File: rtl/link_tx_arbiter.sv
// link_tx_arbiter: round-robin, burst-bounded sharing of one link among gate TX channels.
// The link flit is a combinational view of the owner's input; only arbitration state is stored.
module link_tx_arbiter #(
   parameter int GATE_NUMBER = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int MAX_BURST   = 4
) (
   input logic i_clk,
   input logic i_rst,
   link_tx_arbiter_if.slave bus
);
   localparam int SW = $clog2(GATE_NUMBER);
   localparam int CW = $clog2(MAX_BURST + 1);
   typedef enum logic {IDLE, BURST} state_t;
   state_t          r_state;
   logic [SW-1:0]   r_ptr, r_owner, w_pick, w_next_ptr;
   logic [CW-1:0]   r_cnt;
   logic            w_busy, w_valid, w_last, w_xfer;
   logic [DATA_WIDTH-1:0] w_data [GATE_NUMBER];
   for (genvar g = 0; g < GATE_NUMBER; g++) begin : g_data
      assign w_data[g] = bus.i_data[g*DATA_WIDTH +: DATA_WIDTH];
   end
   // Scan offsets high to low so the smallest cyclic distance from r_ptr wins.
   always_comb begin
      w_pick = r_ptr;
      for (int i = GATE_NUMBER - 1; i >= 0; i--) begin
         logic [SW-1:0] idx;
         idx = SW'((int'(r_ptr) + i) % GATE_NUMBER);
         if (bus.i_req[idx]) w_pick = idx;
      end
   end
   assign w_busy     = r_state == BURST;
   assign w_valid    = w_busy & bus.i_req[r_owner];
   assign w_last     = w_busy & (bus.i_last[r_owner] | (r_cnt == CW'(MAX_BURST - 1)));
   assign w_xfer     = w_valid & bus.i_link_ready;
   assign w_next_ptr = (r_owner == SW'(GATE_NUMBER - 1)) ? '0 : r_owner + 1'b1;
   assign bus.o_pop        = w_xfer ? GATE_NUMBER'(1) << r_owner : '0;
   assign bus.o_link_valid = w_valid;
   assign bus.o_link_data  = w_busy ? w_data[r_owner] : '0;
   assign bus.o_link_src   = w_busy ? r_owner : '0;
   assign bus.o_link_last  = w_last;
   assign bus.o_busy       = w_busy;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_cnt   <= '0;
      end else if (r_state == IDLE) begin
         if (|bus.i_req) begin
            r_state <= BURST;
            r_owner <= w_pick;
            r_cnt   <= '0;
         end
      end else if (!bus.i_req[r_owner] || (w_xfer && w_last)) begin
         r_state <= IDLE;
         r_ptr   <= w_next_ptr;
      end else if (w_xfer) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_link_tx_arbiter.sv
// tb_link_tx_arbiter: table-driven per-cycle vectors plus an async-reset-mid-burst sequence.
module tb_link_tx_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   link_tx_arbiter_if #(.GATE_NUMBER(4), .DATA_WIDTH(32)) bus ();
   link_tx_arbiter #(.GATE_NUMBER(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );
   typedef struct {
      logic [3:0] req;
      logic [3:0] last;
      logic       rdy;
      logic       busy;
      logic       valid;
      logic [1:0] src;
      logic       ll;
      logic [3:0] pop;
   } vec_t;
   vec_t tbl[$];
   int checks = 0;
   int failures = 0;
   function automatic logic [31:0] dat(int row, int k);
      return 32'hA500_0000 | 32'((row & 255) << 8) | 32'(k);
   endfunction
   task automatic add(logic [3:0] req, logic [3:0] last, logic rdy, logic busy, logic valid,
                      logic [1:0] src, logic ll, logic [3:0] pop);
      tbl.push_back('{req: req, last: last, rdy: rdy, busy: busy, valid: valid, src: src, ll: ll, pop: pop});
   endtask
   task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
      end
   endtask
   task automatic drive(int row, logic [3:0] req, logic [3:0] last, logic rdy);
      bus.i_req        = req;
      bus.i_last       = last;
      bus.i_link_ready = rdy;
      bus.i_data       = {dat(row, 3), dat(row, 2), dat(row, 1), dat(row, 0)};
   endtask
   task automatic expect_out(int row, logic busy, logic valid, logic [1:0] src, logic ll,
                             logic [3:0] pop);
      chk("busy",  row, 32'(bus.o_busy),       32'(busy));
      chk("valid", row, 32'(bus.o_link_valid), 32'(valid));
      chk("src",   row, 32'(bus.o_link_src),   32'(src));
      chk("last",  row, 32'(bus.o_link_last),  32'(ll));
      chk("pop",   row, 32'(bus.o_pop),        32'(pop));
      chk("data",  row, bus.o_link_data,       busy ? dat(row, int'(src)) : 32'h0);
   endtask
   initial begin
      drive(0, 4'b0000, 4'b0000, 1'b0);
      // single 2-flit message on channel 2, then a 1-flit message on 3 moving ptr to 0
      add(4'b0100, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
      add(4'b0100, 4'b0000, 1, 1, 1, 2, 0, 4'b0100);
      add(4'b0100, 4'b0100, 1, 1, 1, 2, 1, 4'b0100);
      add(4'b1000, 4'b1000, 1, 0, 0, 0, 0, 4'b0000);
      add(4'b1000, 4'b1000, 1, 1, 1, 3, 1, 4'b1000);
      add(4'b1001, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
      add(4'b1001, 4'b0001, 1, 1, 1, 0, 1, 4'b0001);
      // all channels requesting endless messages: 4-flit bursts, one idle between grants
      for (int gi = 0; gi < 4; gi++) begin
         add(4'b1111, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
         for (int j = 0; j < 4; j++)
            add(4'b1111, 4'b0000, 1, 1, 1, 2'((gi + 1) % 4), j == 3, 4'(1 << ((gi + 1) % 4)));
      end
      // ready stall of 5 cycles at flit 2 of channel 1
      add(4'b0010, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
      add(4'b0010, 4'b0000, 1, 1, 1, 1, 0, 4'b0010);
      for (int j = 0; j < 5; j++) add(4'b0010, 4'b0000, 0, 1, 1, 1, 0, 4'b0000);
      add(4'b0010, 4'b0000, 1, 1, 1, 1, 0, 4'b0010);
      add(4'b0010, 4'b0000, 1, 1, 1, 1, 0, 4'b0010);
      add(4'b0010, 4'b0000, 1, 1, 1, 1, 1, 4'b0010);
      // owner 0 drops after one flit; channel 1 next; channel 0 regranted with fresh count
      add(4'b0011, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
      add(4'b0011, 4'b0000, 1, 1, 1, 0, 0, 4'b0001);
      add(4'b0010, 4'b0000, 1, 1, 0, 0, 0, 4'b0000);
      add(4'b0011, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
      add(4'b0011, 4'b0010, 1, 1, 1, 1, 1, 4'b0010);
      add(4'b0001, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
      for (int j = 0; j < 3; j++) add(4'b0001, 4'b0000, 1, 1, 1, 0, 0, 4'b0001);
      add(4'b0001, 4'b0000, 1, 1, 1, 0, 1, 4'b0001);
      add(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
      #1 expect_out(-1, 0, 0, 0, 0, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int r = 0; r < tbl.size(); r++) begin
         drive(r, tbl[r].req, tbl[r].last, tbl[r].rdy);
         #1 expect_out(r, tbl[r].busy, tbl[r].valid, tbl[r].src, tbl[r].ll, tbl[r].pop);
         @(negedge clk);
      end
      // async reset while owner=1, cnt=2 (ptr is 1 after the table)
      drive(100, 4'b0010, 4'b0000, 1'b1);
      #1 expect_out(100, 0, 0, 0, 0, 4'b0000);
      @(negedge clk);
      drive(101, 4'b0010, 4'b0000, 1'b1);
      #1 expect_out(101, 1, 1, 1, 0, 4'b0010);
      @(negedge clk);
      drive(102, 4'b0010, 4'b0000, 1'b1);
      #1 expect_out(102, 1, 1, 1, 0, 4'b0010);
      @(negedge clk);
      drive(103, 4'b0010, 4'b0000, 1'b1);
      #1 expect_out(103, 1, 1, 1, 0, 4'b0010);
      rst = 1'b1;
      #1 expect_out(104, 0, 0, 0, 0, 4'b0000);
      @(negedge clk);
      drive(105, 4'b0010, 4'b0000, 1'b1);
      #1 expect_out(105, 0, 0, 0, 0, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      drive(106, 4'b1111, 4'b0000, 1'b1);
      #1 expect_out(106, 0, 0, 0, 0, 4'b0000);
      @(negedge clk);
      drive(107, 4'b1111, 4'b0000, 1'b1);
      #1 expect_out(107, 1, 1, 0, 0, 4'b0001);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
